pattern_event_fifo: RTL

- Sits directly downstream of the serial run detector, which emits a 2-bit run code y (00 none, 01/10/11 = run levels).
- Samples that code every clock and turns each new non-zero code into an event record.
- Keeps saturating per-code hit counters and buffers event records in a FIFO.
- Event records drain through a valid/ready interface to a logger/host.

---
 rtl/pattern_event_fifo.sv | 111 +++++++++++
 1 files changed

// File: rtl/pattern_event_fifo.sv
// pattern_event_fifo: converts the run-detector code stream into event records.
// Each new non-zero code becomes one event. Per-code hit counters saturate.
// Records queue in a first-word-fall-through FIFO that drains over valid/ready.
// Optional feature macro: PATTERN_EVT_TIMESTAMP_EN.
//   - Defined: a free-running timestamp is captured into each record.
//   - Undefined: there is no timestamp counter, and the timestamp field is always 0.
module pattern_event_fifo #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               code,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_W+1:0]          out_data,
  output logic [CNT_W-1:0]         cnt1,
  output logic [CNT_W-1:0]         cnt2,
  output logic [CNT_W-1:0]         cnt3,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [1:0]       prev_code;
  logic [TS_W-1:0]  ts_now;
  logic [TS_W+1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] hits [3];
  logic             evt;
  logic             pop;
  logic             push;
  logic             full;

  // An event is a non-zero code that differs from the previous cycle's code.
  assign evt  = (code != 2'b00) && (code != prev_code);
  assign full = (level == LVL_W'(DEPTH));

  // A pop frees a slot on the same edge, so a push into a full FIFO is accepted then.
  assign pop  = out_valid && out_ready;
  assign push = evt && (!full || pop);

  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  assign cnt1 = hits[0];
  assign cnt2 = hits[1];
  assign cnt3 = hits[2];

`ifdef PATTERN_EVT_TIMESTAMP_EN
  // Free-running timestamp; wraps naturally at TS_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_now <= '0;
    else     ts_now <= ts_now + TS_W'(1);
  end
`else
  assign ts_now = '0;
`endif

  // Previous-code register used for edge-style event detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_code <= 2'b00;
    else     prev_code <= code;
  end

  // Record storage; the written record carries the timestamp of the event cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {code, ts_now};
  end

  // Pointers and occupancy. Pointers wrap because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Sticky drop flag. Clear takes priority over a simultaneous drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      overflow <= 1'b0;
    else if (clear)               overflow <= 1'b0;
    else if (evt && full && !pop) overflow <= 1'b1;
  end

  // One saturating hit counter per non-zero code. Dropped events still count.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_hits
      // Count events of code gi+1. Clear overrides a coincident event.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          hits[gi] <= '0;
        else if (clear)
          hits[gi] <= '0;
        else if (evt && (code == 2'(gi + 1)) && (hits[gi] != '1))
          hits[gi] <= hits[gi] + CNT_W'(1);
      end
    end
  endgenerate

endmodule
